// File: rtl/mode1_max_accum_pkg.sv
// Shared widths, compare configuration and FSM encoding for the max-reduction stage.
package mode1_max_accum_pkg;

  localparam int unsigned DATAWIDTH       = 16;
  localparam int unsigned MANTISSA        = 10;
  localparam int unsigned EXPONENT        = 5;
  localparam int unsigned IEEE_COMPLIANCE = 0;

  typedef enum logic [1:0] {
    MAXST_IDLE  = 2'd0,
    MAXST_ACCUM = 2'd1,
    MAXST_DRAIN = 2'd2,
    MAXST_DONE  = 2'd3
  } maxst_t;

endpackage

// File: rtl/mode1_max_accum_fp_max2.sv
// Combinational fp max of two operands; ties (including +0 vs -0) return operand a.
// With IEEE_COMPLIANCE=0 denormals compare as zero, matching the fp compare macro.
module mode1_max_accum_fp_max2
  import mode1_max_accum_pkg::*;
#(
  parameter int unsigned MAN_W = MANTISSA,
  parameter int unsigned EXP_W = EXPONENT,
  parameter int unsigned IEEE  = IEEE_COMPLIANCE
) (
  input  logic [MAN_W+EXP_W:0] a,
  input  logic [MAN_W+EXP_W:0] b,
  output logic [MAN_W+EXP_W:0] max_c
);

  localparam int unsigned W = MAN_W + EXP_W + 1;

  logic [W-2:0] mag_a;
  logic [W-2:0] mag_b;
  logic         a_zero;
  logic         b_zero;
  logic         a_neg;
  logic         b_neg;
  logic         b_gt;

  // Sign/magnitude ordering with zero classes folded so that signed zeros tie.
  always_comb begin
    mag_a = a[W-2:0];
    mag_b = b[W-2:0];
    if (IEEE == 0) begin
      a_zero = (a[W-2:MAN_W] == '0);
      b_zero = (b[W-2:MAN_W] == '0);
    end else begin
      a_zero = (mag_a == '0);
      b_zero = (mag_b == '0);
    end
    a_neg = a[W-1] & ~a_zero;
    b_neg = b[W-1] & ~b_zero;
    b_gt  = 1'b0;
    if (a_zero && b_zero) begin
      b_gt = 1'b0;
    end else if (a_neg != b_neg) begin
      b_gt = a_neg;
    end else if (!a_neg) begin
      b_gt = (mag_b > mag_a);
    end else begin
      b_gt = (mag_b < mag_a);
    end
    max_c = b_gt ? b : a;
  end

endmodule

// File: rtl/mode1_max_accum.sv
// Streaming max reduction: two fp16 lanes per beat, pair-compare stage then running-max stage.
// The final maximum is held on max_out with max_valid high until the next start or reset.
module mode1_max_accum
  import mode1_max_accum_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [DATAWIDTH-1:0] inp0,
  input  logic [DATAWIDTH-1:0] inp1,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] max_out,
  output logic                 max_valid,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 cnt_ovf
);

  maxst_t               state;
  maxst_t               next_state;
  logic                 drain_cnt;
  logic                 accept_c;
  logic                 v1;
  logic                 last1;
  logic                 first;
  logic [DATAWIDTH-1:0] pmax;
  logic [DATAWIDTH-1:0] pair_max_c;
  logic [DATAWIDTH-1:0] acc_max_c;

  mode1_max_accum_fp_max2 u_pair_max (
    .a     (inp0),
    .b     (inp1),
    .max_c (pair_max_c)
  );

  mode1_max_accum_fp_max2 u_acc_max (
    .a     (max_out),
    .b     (pmax),
    .max_c (acc_max_c)
  );

  // A start cycle never accepts a beat: the vector it would belong to is being discarded.
  always_comb begin
    accept_c = in_valid & in_ready & ~start;
  end

  // Next-state logic; start restarts from any state.
  always_comb begin
    next_state = state;
    unique case (state)
      MAXST_IDLE:  next_state = MAXST_IDLE;
      MAXST_ACCUM: if (accept_c && in_last) next_state = MAXST_DRAIN;
      MAXST_DRAIN: if (drain_cnt) next_state = MAXST_DONE;
      MAXST_DONE:  next_state = MAXST_DONE;
    endcase
    if (start) next_state = MAXST_ACCUM;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= MAXST_IDLE;
    else       state <= next_state;
  end

  // Registered ready and two-cycle drain timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      in_ready  <= (next_state == MAXST_ACCUM);
      drain_cnt <= (state == MAXST_DRAIN) && (next_state == MAXST_DRAIN);
    end
  end

  // Saturating beat counter with sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      beat_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (accept_c) begin
      if (&beat_cnt) cnt_ovf  <= 1'b1;
      else           beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end

  // Stage 1: pair max with valid/last tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      pmax  <= '0;
    end else begin
      v1    <= accept_c;
      last1 <= in_last;
      if (accept_c) pmax <= pair_max_c;
    end
  end

  // Stage 2: the first beat loads the running max directly, later beats keep the larger value.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_out   <= '0;
      max_valid <= 1'b0;
      first     <= 1'b0;
    end else if (start) begin
      max_valid <= 1'b0;
      first     <= 1'b1;
    end else if (v1) begin
      max_out   <= first ? pmax : acc_max_c;
      first     <= 1'b0;
      max_valid <= last1;
    end
  end

endmodule
